// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: op codes, default flag positions
// and the multiply/divide sequencing states.
package alu_pkg;

    localparam logic [3:0] ALU_OP_ADD   = 4'd0;
    localparam logic [3:0] ALU_OP_SUB   = 4'd1;
    localparam logic [3:0] ALU_OP_AND   = 4'd2;
    localparam logic [3:0] ALU_OP_OR    = 4'd3;
    localparam logic [3:0] ALU_OP_SLT   = 4'd4;
    localparam logic [3:0] ALU_OP_PASSB = 4'd5;
    localparam logic [3:0] ALU_OP_SLL   = 4'd6;
    localparam logic [3:0] ALU_OP_SRL   = 4'd7;
    localparam logic [3:0] ALU_OP_SRA   = 4'd8;
    localparam logic [3:0] ALU_OP_XOR   = 4'd9;
    localparam logic [3:0] ALU_OP_NOR   = 4'd10;
    localparam logic [3:0] ALU_OP_SLTU  = 4'd11;
    localparam logic [3:0] ALU_OP_MULT  = 4'd12;
    localparam logic [3:0] ALU_OP_MULTU = 4'd13;
    localparam logic [3:0] ALU_OP_DIV   = 4'd14;
    localparam logic [3:0] ALU_OP_DIVU  = 4'd15;

    localparam int ALU_ZERO_BIT = 0;
    localparam int ALU_OVF_BIT  = 1;
    localparam int ALU_DIVZ_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ITER,
        ST_FIX
    } alu_state_e;

    // Ops 12..15 share the 2'b11 prefix and go through the iterative unit.
    function automatic logic is_md_op(input logic [3:0] op);
        return op[3] & op[2];
    endfunction

endpackage

// File: rtl/md_iter.sv
// Unsigned WIDTH-step iterative engine: shift-add multiply or restoring divide.
// o_hi/o_lo present the post-step value, so they are final while o_done is high.
module md_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_mul,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             r_busy;
    logic             r_mul;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_ph;
    logic [WIDTH-1:0] r_pl;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH-1:0] w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_ph_next;
    logic [WIDTH-1:0] w_pl_next;

    // r_ph holds the partial product high half / running remainder,
    // r_pl holds the multiplier / dividend being shifted out and quotient bits in.
    always_comb begin
        w_sum    = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_b} : '0);
        w_rem_sh = {r_ph, r_pl[WIDTH-1]};
        w_qbit   = (w_rem_sh >= {1'b0, r_b});
        w_diff   = w_rem_sh[WIDTH-1:0] - r_b;
        if (r_mul) begin
            w_ph_next = w_sum[WIDTH:1];
            w_pl_next = {w_sum[0], r_pl[WIDTH-1:1]};
        end else begin
            w_ph_next = w_qbit ? w_diff : w_rem_sh[WIDTH-1:0];
            w_pl_next = {r_pl[WIDTH-2:0], w_qbit};
        end
    end

    assign o_done = r_busy && (r_cnt == CNT_W'(1));
    assign o_hi   = w_ph_next;
    assign o_lo   = w_pl_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_mul  <= 1'b0;
            r_cnt  <= '0;
            r_b    <= '0;
            r_ph   <= '0;
            r_pl   <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_mul  <= i_mul;
            r_cnt  <= CNT_W'(WIDTH);
            r_b    <= i_b;
            r_ph   <= '0;
            r_pl   <= i_a;
        end else if (r_busy) begin
            r_ph  <= w_ph_next;
            r_pl  <= w_pl_next;
            r_cnt <= r_cnt - CNT_W'(1);
            if (o_done) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_md.sv
// EX-stage ALU: single-cycle logic/arith/shift ops plus iterative MULT/DIV into
// HI/LO, with the zero/overflow/divide-by-zero flag word.
module alu_md
    import alu_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FLAG_W   = 32,
    parameter int ZERO_BIT = ALU_ZERO_BIT,
    parameter int OVF_BIT  = ALU_OVF_BIT,
    parameter int DIVZ_BIT = ALU_DIVZ_BIT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [3:0]                 op,
    input  logic [WIDTH-1:0]           x,
    input  logic [WIDTH-1:0]           y,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    input  logic [FLAG_W-1:0]          flag_in,
    output logic [WIDTH-1:0]           result,
    output logic [FLAG_W-1:0]          nflag,
    output logic [WIDTH-1:0]           hi,
    output logic [WIDTH-1:0]           lo,
    output logic                       busy,
    output logic                       done
);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_e        r_state;
    alu_state_e        w_state_next;
    logic              w_accept;
    logic              w_busy;

    logic [1:0]        r_md_op;
    logic [WIDTH-1:0]  r_x;
    logic [WIDTH-1:0]  r_y;
    logic [FLAG_W-1:0] r_flag;
    logic              r_neg_p;
    logic              r_neg_r;
    logic [WIDTH-1:0]  r_result;
    logic [FLAG_W-1:0] r_nflag;
    logic [WIDTH-1:0]  r_hi;
    logic [WIDTH-1:0]  r_lo;
    logic              r_done;

    logic [WIDTH-1:0]  w_sum;
    logic [WIDTH-1:0]  w_diff;
    logic [WIDTH-1:0]  w_res;
    logic              w_ovf;
    logic [FLAG_W-1:0] w_sc_flag;
    logic [FLAG_W-1:0] w_md_flag;

    logic              w_x_neg;
    logic              w_y_neg;
    logic [WIDTH-1:0]  w_abs_x;
    logic [WIDTH-1:0]  w_abs_y;
    logic              w_md_start;
    logic              w_md_done;
    logic [WIDTH-1:0]  w_it_hi;
    logic [WIDTH-1:0]  w_it_lo;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]  w_fix_hi;
    logic [WIDTH-1:0]  w_fix_lo;
    logic              w_divz;
    logic              w_md_ovf;
    logic              w_md_zero;

    assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_FIX));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b0;
        case (r_state)
            ST_IDLE, ST_FIX: begin
                w_state_next = (w_accept && is_md_op(op)) ? ST_LOAD : ST_IDLE;
            end
            ST_LOAD: begin
                w_busy       = 1'b1;
                w_state_next = ST_ITER;
            end
            ST_ITER: begin
                w_busy = 1'b1;
                if (w_md_done) begin
                    w_state_next = ST_FIX;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_sum  = x + y;
        w_diff = x - y;
        w_ovf  = 1'b0;
        case (op)
            ALU_OP_ADD: begin
                w_res = w_sum;
                w_ovf = (x[WIDTH-1] == y[WIDTH-1]) && (w_sum[WIDTH-1] != x[WIDTH-1]);
            end
            ALU_OP_SUB: begin
                w_res = w_diff;
                w_ovf = (x[WIDTH-1] != y[WIDTH-1]) && (w_diff[WIDTH-1] != x[WIDTH-1]);
            end
            ALU_OP_AND:   w_res = x & y;
            ALU_OP_OR:    w_res = x | y;
            ALU_OP_SLT:   w_res = {{(WIDTH-1){1'b0}}, ($signed(x) < $signed(y))};
            ALU_OP_PASSB: w_res = y;
            ALU_OP_SLL:   w_res = y << shamt;
            ALU_OP_SRL:   w_res = y >> shamt;
            ALU_OP_SRA:   w_res = $signed(y) >>> shamt;
            ALU_OP_XOR:   w_res = x ^ y;
            ALU_OP_NOR:   w_res = ~(x | y);
            ALU_OP_SLTU:  w_res = {{(WIDTH-1){1'b0}}, (x < y)};
            default:      w_res = '0;
        endcase
    end

    // Signed ops run the engine on magnitudes; signs are reapplied on completion.
    assign w_x_neg    = ~r_md_op[0] & r_x[WIDTH-1];
    assign w_y_neg    = ~r_md_op[0] & r_y[WIDTH-1];
    assign w_abs_x    = w_x_neg ? -r_x : r_x;
    assign w_abs_y    = w_y_neg ? -r_y : r_y;
    assign w_md_start = (r_state == ST_LOAD);

    md_iter #(
        .WIDTH(WIDTH)
    ) u_md_iter (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_md_start),
        .i_mul   (~r_md_op[1]),
        .i_a     (w_abs_x),
        .i_b     (w_abs_y),
        .o_done  (w_md_done),
        .o_hi    (w_it_hi),
        .o_lo    (w_it_lo)
    );

    assign w_divz   = r_md_op[1] & (r_y == '0);
    assign w_md_ovf = r_md_op[1] & ~r_md_op[0] & (r_x == MOST_NEG) & (r_y == '1);

    always_comb begin
        w_prod_fix = r_neg_p ? -{w_it_hi, w_it_lo} : {w_it_hi, w_it_lo};
        w_fix_hi   = w_prod_fix[2*WIDTH-1:WIDTH];
        w_fix_lo   = w_prod_fix[WIDTH-1:0];
        w_md_zero  = ({w_it_hi, w_it_lo} == '0);
        if (r_md_op[1]) begin
            if (w_divz) begin
                w_fix_hi = r_x;
                w_fix_lo = '1;
            end else begin
                w_fix_hi = r_neg_r ? -w_it_hi : w_it_hi;
                w_fix_lo = r_neg_p ? -w_it_lo : w_it_lo;
            end
            w_md_zero = ~w_divz & (w_fix_lo == '0);
        end
    end

    // Overflow is sticky; divide-by-zero only ever gets set by a divide.
    for (genvar gi = 0; gi < FLAG_W; gi++) begin : g_flag
        if (gi == ZERO_BIT) begin : g_zero
            assign w_sc_flag[gi] = (w_res == '0);
            assign w_md_flag[gi] = w_md_zero;
        end else if (gi == OVF_BIT) begin : g_ovf
            assign w_sc_flag[gi] = flag_in[gi] | w_ovf;
            assign w_md_flag[gi] = r_flag[gi] | w_md_ovf;
        end else if (gi == DIVZ_BIT) begin : g_divz
            assign w_sc_flag[gi] = flag_in[gi];
            assign w_md_flag[gi] = r_flag[gi] | w_divz;
        end else begin : g_pass
            assign w_sc_flag[gi] = flag_in[gi];
            assign w_md_flag[gi] = r_flag[gi];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_md_op  <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_flag   <= '0;
            r_neg_p  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_nflag  <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_md_op <= op[1:0];
                r_x     <= x;
                r_y     <= y;
                r_flag  <= flag_in;
                if (!is_md_op(op)) begin
                    r_result <= w_res;
                    r_nflag  <= w_sc_flag;
                    r_done   <= 1'b1;
                end
            end
            if (r_state == ST_LOAD) begin
                r_neg_p <= w_x_neg ^ w_y_neg;
                r_neg_r <= w_x_neg;
            end
            if (w_md_done) begin
                r_hi    <= w_fix_hi;
                r_lo    <= w_fix_lo;
                r_nflag <= w_md_flag;
                r_done  <= 1'b1;
            end
        end
    end

    assign result = r_result;
    assign nflag  = r_nflag;
    assign hi     = r_hi;
    assign lo     = r_lo;
    assign busy   = w_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_alu_md.sv
// Scoreboard bench for alu_md: a behavioural model queues expected results at
// issue time; a monitor pops and compares them on every done pulse.
module tb_alu_md;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  shamt;
    logic [31:0] flag_in;
    logic [31:0] result;
    logic [31:0] nflag;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] res;
        logic [31:0] flg;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_res;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    int          total;
    int          bad;

    alu_md u_dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .x       (x),
        .y       (y),
        .shamt   (shamt),
        .flag_in (flag_in),
        .result  (result),
        .nflag   (nflag),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] s, input logic [31:0] f);
        exp_t        e;
        logic [63:0] p;
        int          sa;
        int          sb;
        logic        ovf;
        e.op  = o;
        e.res = m_res;
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.flg = f;
        ovf   = 1'b0;
        sa    = a;
        sb    = b;
        case (o)
            4'd0: begin e.res = a + b; ovf = (a[31] == b[31]) && (e.res[31] != a[31]); end
            4'd1: begin e.res = a - b; ovf = (a[31] != b[31]) && (e.res[31] != a[31]); end
            4'd2: e.res = a & b;
            4'd3: e.res = a | b;
            4'd4: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd5: e.res = b;
            4'd6: e.res = b << s;
            4'd7: e.res = b >> s;
            4'd8: e.res = $signed(b) >>> s;
            4'd9: e.res = a ^ b;
            4'd10: e.res = ~(a | b);
            4'd11: e.res = (a < b) ? 32'd1 : 32'd0;
            4'd12: begin p = longint'(sa) * longint'(sb); {e.hi, e.lo} = p; end
            4'd13: begin p = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = p; end
            4'd14: begin
                if (b == 32'd0) begin
                    e.lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = a;
                    e.hi = 32'd0;
                    ovf  = 1'b1;
                end else begin
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end
            end
            default: begin
                if (b != 32'd0) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        if (o < 4'd12) begin
            e.flg[0] = (e.res == 32'd0);
        end else if (o < 4'd14) begin
            e.flg[0] = ({e.hi, e.lo} == 64'd0);
        end else if (b == 32'd0) begin
            e.lo     = 32'hFFFF_FFFF;
            e.hi     = a;
            e.flg[0] = 1'b0;
            e.flg[2] = 1'b1;
        end else begin
            e.flg[0] = (e.lo == 32'd0);
        end
        if (ovf) e.flg[1] = 1'b1;
        return e;
    endfunction

    // Caller guarantees the DUT is idle (or showing done) so the op is accepted.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] s, input logic [31:0] f);
        exp_t e;
        e     = model(o, a, b, s, f);
        m_res = e.res;
        m_hi  = e.hi;
        m_lo  = e.lo;
        exp_q.push_back(e);
        start = 1'b1; op = o; x = a; y = b; shamt = s; flag_in = f;
        @(posedge clk);
        #1;
        start = 1'b0; x = $urandom; y = $urandom; shamt = 5'($urandom); flag_in = $urandom;
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) begin
                ok = 1;
                break;
            end
        end
        check("wait_idle", ok, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("result", result, e.res);
                check("nflag", nflag, e.flg);
                check("hi", hi, e.hi);
                check("lo", lo, e.lo);
                $display("txn op=%0d result=%h nflag=%h hi=%h lo=%h", e.op, result, nflag, hi, lo);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int done_at;
        int ndone;
        total = 0; bad = 0;
        m_res = '0; m_hi = '0; m_lo = '0;
        rst = 1'b1; start = 1'b0; op = '0; x = '0; y = '0; shamt = '0; flag_in = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_nflag", nflag, 32'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy_done", {busy, done}, 2'b00);

        // Sticky overflow, zero flag, shifts.
        issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'd0);
        issue(4'd2, 32'd0, 32'd5, 5'd0, 32'd2);
        issue(4'd2, 32'd0, 32'd5, 5'd0, 32'd0);
        issue(4'd8, 32'd0, 32'h8000_0010, 5'd4, 32'd0);
        issue(4'd7, 32'd0, 32'h8000_0010, 5'd4, 32'd0);
        issue(4'd6, 32'd0, 32'd1, 5'd31, 32'd0);
        issue(4'd1, 32'd5, 32'd5, 5'd0, 32'd0);
        issue(4'd1, 32'h8000_0000, 32'd1, 5'd0, 32'd0);
        for (int i = 0; i < 12; i++) begin
            issue(4'(i), $urandom, $urandom, 5'($urandom), $urandom);
        end
        wait_idle();

        // Signed multiply: busy window, done latency, starts ignored while busy.
        issue(4'd12, 32'hFFFF_FFFD, 32'd7, 5'd0, 32'd0);
        nb = 0;
        done_at = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin
                done_at = c;
                break;
            end
            if (busy) nb++;
            if (c == 3 || c == 20) begin
                start = 1'b1; op = 4'd0; x = 32'd1; y = 32'd1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        check("mult_busy_cycles", nb, 33);
        check("mult_done_cycle", done_at, 33);
        check("mult_done_not_busy", busy, 1'b0);
        wait_idle();

        // Divides, overflow case, divide by zero.
        issue(4'd14, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'd0);
        wait_idle();
        issue(4'd15, 32'd7, 32'd2, 5'd0, 32'd0);
        wait_idle();
        issue(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0);
        wait_idle();
        issue(4'd15, 32'h0000_1234, 32'd0, 5'd0, 32'd0);
        wait_idle();
        issue(4'd14, 32'hFFFF_FFFB, 32'd0, 5'd0, 32'd0);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            issue(4'(12 + i), $urandom, $urandom, 5'd0, $urandom);
            wait_idle();
        end

        // Reset while MULTU is iterating.
        issue(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0, 32'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        m_res = '0; m_hi = '0; m_lo = '0;
        @(negedge clk);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_res_flag", {result, nflag}, 64'd0);
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        check("no_done_after_abort", ndone, 0);

        // Back-to-back: ADD issued on the MULTU done cycle.
        issue(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd0);
        done_at = -1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (done) begin
                done_at = c;
                break;
            end
        end
        check("b2b_mult_done", done_at, 33);
        issue(4'd0, 32'd10, 32'd20, 5'd0, 32'd0);
        @(negedge clk);
        check("b2b_add_done", {done, busy}, 2'b10);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
